// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcode constants,
// controller state encoding, settle-counter width and the opcode legality check.
package alu_pkg;

   // Width of the settle counter; covers SETTLE_CYCLES up to 15.
   localparam int CNT_W = 4;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_BEQ = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   // An illegal opcode is reported from ST_RESP with rsp_err set, so no separate error state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_BEQ, OP_SUB, OP_SLT: is_legal_op = 1'b1;
         default:                                       is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arb2.sv
// Two-requester grant logic for the shared ALU.
// ALU_SHARE_RR_EN defined: ties alternate (round-robin on last_grant).
// ALU_SHARE_RR_EN undefined: req0 wins every tie, no history register.
module alu_arb2
   import alu_pkg::*;
(
`ifdef ALU_SHARE_RR_EN
   input  logic clk,
   input  logic reset,
   input  logic accept_i,
`endif
   input  logic valid0_i,
   input  logic valid1_i,
   output logic any_valid_o,
   output logic grant_o
);

   logic tie_grant;

`ifdef ALU_SHARE_RR_EN
   logic last_grant_q;

   // Remember the winner of the last accepted request; starts at 1 so req0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else if (accept_i) begin
         last_grant_q <= grant_o;
      end
   end

   assign tie_grant = ~last_grant_q;
`else
   assign tie_grant = 1'b0;
`endif

   assign any_valid_o = valid0_i | valid1_i;

   // Grant the only valid requester, or apply the tie policy when both are valid.
   always_comb begin
      // NOTE: default assignment first so every path drives grant_o and no latch is inferred.
      grant_o = 1'b0;
      if (valid0_i && valid1_i) begin
         grant_o = tie_grant;
      end else if (valid1_i) begin
         grant_o = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 32-bit ALU between two requesters.
// Accepts one request in IDLE, holds its operands on the ALU for SETTLE_CYCLES,
// captures result/zero, then presents a tagged response until consumed.
// Illegal opcodes skip the ALU and respond immediately with rsp_err set.
// Tie policy selected by the ALU_SHARE_RR_EN macro (see alu_arb2).
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_err,

   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_sum,
   input  logic        alu_zero
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       alu_a_q;
   logic [31:0]       alu_b_q;
   logic [2:0]        alu_op_q;
   logic              rsp_id_q;
   logic [31:0]       rsp_result_q;
   logic              rsp_zero_q;
   logic              rsp_err_q;

   logic              any_valid;
   logic              grant;
   logic              accept_d;
   logic [2:0]        sel_op;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;

   alu_arb2 u_arb (
`ifdef ALU_SHARE_RR_EN
      .clk         (clk),
      .reset       (reset),
      .accept_i    (accept_d),
`endif
      .valid0_i    (req0_valid),
      .valid1_i    (req1_valid),
      .any_valid_o (any_valid),
      .grant_o     (grant)
   );

   // Readies are mutually exclusive because they decode a single grant bit.
   assign req0_ready = !reset && (state_q == ST_IDLE) && any_valid && !grant;
   assign req1_ready = !reset && (state_q == ST_IDLE) && any_valid &&  grant;
   assign accept_d   = req0_ready | req1_ready;

   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;

   // ALU inputs come only from registers, so they cannot move during the settle window.
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;

   // Controller FSM: accept, settle, respond; also owns all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the datapath registers are reset as well, because their values are visible on outputs.
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= OP_AND;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  rsp_id_q <= grant;
                  if (is_legal_op(sel_op)) begin
                     alu_a_q  <= sel_a;
                     alu_b_q  <= sel_b;
                     alu_op_q <= sel_op;
                     cnt_q    <= CNT_LOAD;
                     state_q  <= ST_SETTLE;
                  end else begin
                     // Illegal op never reaches the ALU; its last operands stay put.
                     rsp_result_q <= '0;
                     rsp_zero_q   <= 1'b0;
                     rsp_err_q    <= 1'b1;
                     state_q      <= ST_RESP;
                  end
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  rsp_result_q <= alu_sum;
                  rsp_zero_q   <= alu_zero;
                  rsp_err_q    <= 1'b0;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with SETTLE_CYCLES=4.
// A behavioural ALU model (ideal or delayed output) sits beside the DUT.
// Tie expectations follow ALU_SHARE_RR_EN.
module tb_alu_share_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [31:0] rsp_result;
   logic [31:0] alu_a, alu_b, alu_sum;
   logic [2:0]  alu_op;
   logic        alu_zero;
   logic        use_delay;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sum(alu_sum), .alu_zero(alu_zero)
   );

   // Behavioural ALU: {zero, result}
   function automatic logic [32:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         OP_AND:         r = a & b;
         OP_OR:          r = a | b;
         OP_ADD:         r = a + b;
         OP_BEQ, OP_SUB: r = a - b;
         OP_SLT:         r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default:        r = 32'd0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   logic [32:0] alu_ideal, alu_late;
   assign alu_ideal = alu_model(alu_op, alu_a, alu_b);
   assign #13 alu_late = alu_ideal;
   assign {alu_zero, alu_sum} = use_delay ? alu_late : alu_ideal;

   task automatic drive_req(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   // Counts negedges until rsp_valid, dropping request valids after the accept.
   task automatic wait_rsp(input int limit, output int cycles, output bit ok);
      ok = 1'b0;
      cycles = 0;
      while (!ok && cycles < limit) begin
         @(negedge clk);
         cycles++;
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         if (rsp_valid) ok = 1'b1;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      req0_valid = 1'b1;
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready}); else passes++;
      checks++; if (rsp_result !== 32'd0) $display("FAIL reset_result: got %0d want 0", rsp_result); else passes++;
      checks++; if ({alu_a, alu_b, alu_op} !== 67'd0)
         $display("FAIL reset_alu: got a=%0d b=%0d op=%b want 0 0 000", alu_a, alu_b, alu_op); else passes++;
      req0_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b0)
         $display("FAIL idle_no_req: got %b want 000", {req0_ready, req1_ready, rsp_valid}); else passes++;
   endtask

   task automatic test_add();
      int cyc; bit ok;
      @(negedge clk);
      drive_req(1'b0, OP_ADD, 32'd1538, 32'd2155);
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready}); else passes++;
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || cyc != 5) $display("FAIL add_latency: got %0d (seen=%0d) want 5", cyc, ok); else passes++;
      checks++; if (rsp_result !== 32'd3693) $display("FAIL add_result: got %0d want 3693", rsp_result); else passes++;
      checks++; if ({rsp_id, rsp_err} !== 2'b00) $display("FAIL add_id_err: got %b want 00", {rsp_id, rsp_err}); else passes++;
      checks++; if (alu_op !== OP_ADD) $display("FAIL add_alu_op: got %b want 010", alu_op); else passes++;
      consume();
      checks++; if (rsp_valid !== 1'b0) $display("FAIL add_handshake: got rsp_valid=%0d want 0", rsp_valid); else passes++;
   endtask

   task automatic test_ties();
      int ids[4]; int res[4]; int at[4]; int n; bit both_hi; int exp_id; int exp_res;
      n = 0; both_hi = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      drive_req(1'b0, OP_SUB, 32'd567953, 32'd213534);
      drive_req(1'b1, OP_AND, 32'd134, 32'd198);
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) both_hi = 1'b1;
         if (rsp_valid) begin
            ids[n] = int'(rsp_id); res[n] = int'(rsp_result); at[n] = c; n++;
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (8) @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (n != 4) $display("FAIL tie_count: got %0d responses want 4", n); else passes++;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_SHARE_RR_EN
         exp_id = k % 2;
`else
         exp_id = 0;
`endif
         exp_res = (exp_id == 1) ? 134 : 354419;
         checks++; if (ids[k] != exp_id) $display("FAIL tie_id[%0d]: got %0d want %0d", k, ids[k], exp_id); else passes++;
         checks++; if (res[k] != exp_res) $display("FAIL tie_result[%0d]: got %0d want %0d", k, res[k], exp_res); else passes++;
      end
      checks++; if (at[1] - at[0] != 6) $display("FAIL tie_throughput: got %0d cycles want 6", at[1] - at[0]); else passes++;
      checks++; if (both_hi) $display("FAIL tie_both_ready: got both readies high want never"); else passes++;
   endtask

   task automatic test_beq();
      int cyc; bit ok;
      use_delay = 1'b1;
      @(negedge clk);
      drive_req(1'b1, OP_BEQ, 32'd218, 32'd218);
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || cyc != 5) $display("FAIL beq_eq_latency: got %0d (seen=%0d) want 5", cyc, ok); else passes++;
      checks++; if ({rsp_id, rsp_zero, rsp_err} !== 3'b110) $display("FAIL beq_eq_flags: got %b want 110", {rsp_id, rsp_zero, rsp_err}); else passes++;
      consume();
      @(negedge clk);
      drive_req(1'b0, OP_BEQ, 32'd564, 32'd1345);
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || rsp_zero !== 1'b0) $display("FAIL beq_ne_zero: got %0d (seen=%0d) want 0", rsp_zero, ok); else passes++;
      consume();
      @(negedge clk);
      drive_req(1'b0, OP_SLT, 32'd111111, 32'd1);
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || rsp_result !== 32'd0) $display("FAIL slt_result: got %0d (seen=%0d) want 0", rsp_result, ok); else passes++;
      consume();
      use_delay = 1'b0;
   endtask

   task automatic test_illegal();
      int cyc; bit ok;
      @(negedge clk);
      drive_req(1'b0, 3'b011, 32'd5, 32'd6);
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || cyc != 1) $display("FAIL illegal_latency: got %0d (seen=%0d) want 1", cyc, ok); else passes++;
      checks++; if ({rsp_err, rsp_zero, rsp_id} !== 3'b100) $display("FAIL illegal_flags: got %b want 100", {rsp_err, rsp_zero, rsp_id}); else passes++;
      checks++; if (rsp_result !== 32'd0) $display("FAIL illegal_result: got %0d want 0", rsp_result); else passes++;
      checks++; if (alu_op !== OP_SLT || alu_a !== 32'd111111)
         $display("FAIL illegal_alu_hold: got op=%b a=%0d want 111 111111", alu_op, alu_a); else passes++;
      consume();
      @(negedge clk);
      drive_req(1'b1, 3'b101, 32'd9, 32'd9);
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || cyc != 1 || {rsp_err, rsp_id} !== 2'b11)
         $display("FAIL illegal_req1: got cyc=%0d err_id=%b want 1 11", cyc, {rsp_err, rsp_id}); else passes++;
      consume();
   endtask

   task automatic test_backpressure();
      int cyc; bit ok;
      @(negedge clk);
      drive_req(1'b0, OP_OR, 32'h0000_00F0, 32'h0000_000F);
      wait_rsp(20, cyc, ok);
      drive_req(1'b1, OP_ADD, 32'd10, 32'd20);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++; if (!ok || {rsp_valid, rsp_id, rsp_err, rsp_zero, req0_ready, req1_ready} !== 6'b100000 || rsp_result !== 32'd255)
            $display("FAIL bp_hold[%0d]: got flags=%b result=%0d want 100000 255", k,
                     {rsp_valid, rsp_id, rsp_err, rsp_zero, req0_ready, req1_ready}, rsp_result); else passes++;
      end
      consume();
      #1;
      checks++; if ({rsp_valid, req1_ready} !== 2'b01) $display("FAIL bp_resume: got valid_ready=%b want 01", {rsp_valid, req1_ready}); else passes++;
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || cyc != 5 || rsp_id !== 1'b1 || rsp_result !== 32'd30)
         $display("FAIL bp_next: got cyc=%0d id=%0d result=%0d want 5 1 30", cyc, rsp_id, rsp_result); else passes++;
      consume();
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok; bit seen;
      @(negedge clk);
      drive_req(1'b0, OP_ADD, 32'd100, 32'd200);
      #1;
      checks++; if (req0_ready !== 1'b1) $display("FAIL mid_accept: got %0d want 1", req0_ready); else passes++;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready} !== 6'b0 || rsp_result !== 32'd0)
         $display("FAIL mid_rsp_reset: got flags=%b result=%0d want 000000 0",
                  {rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready}, rsp_result); else passes++;
      checks++; if ({alu_a, alu_b, alu_op} !== 67'd0)
         $display("FAIL mid_alu_reset: got a=%0d b=%0d op=%b want 0 0 000", alu_a, alu_b, alu_op); else passes++;
      reset = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      checks++; if (seen) $display("FAIL mid_no_rsp: got a response want none"); else passes++;
      drive_req(1'b1, OP_ADD, 32'd7, 32'd8);
      #1;
      checks++; if (req1_ready !== 1'b1) $display("FAIL mid_reaccept: got %0d want 1", req1_ready); else passes++;
      wait_rsp(20, cyc, ok);
      checks++; if (!ok || cyc != 5 || rsp_id !== 1'b1 || rsp_result !== 32'd15)
         $display("FAIL mid_after: got cyc=%0d id=%0d result=%0d want 5 1 15", cyc, rsp_id, rsp_result); else passes++;
      consume();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; use_delay = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = OP_AND; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = OP_AND; req1_a = '0; req1_b = '0;
      test_reset();
      test_add();
      test_ties();
      test_beq();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
